// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multiply/divide unit with HI/LO registers for the execute
//               stage. mult/multu/div/divu hold busy for a fixed latency and
//               commit HI/LO on the last busy cycle; mthi/mtlo write at once.
//               Optional divider: define MD_UNIT_DIV_EN to include div/divu.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

`ifdef MD_UNIT_DIV_EN
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
`else
  localparam int MAX_LAT = MULT_LAT;
`endif
  localparam int CW = $clog2(MAX_LAT) + 1;

  // Latencies below one are not supported; this branch only marks the legal
  // range and elaborates to nothing.
  if (MULT_LAT < 1 || DIV_LAT < 1) begin : g_lat_range_illegal
  end

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic             r_wr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Full-width products, sign- or zero-extended operands.
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;

  assign w_prod_s = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                    $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign w_prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

`ifdef MD_UNIT_DIV_EN
  // Signed division is done on magnitudes and the signs reapplied. The
  // most-negative / -1 case falls out naturally: the quotient magnitude
  // 2^(W-1) re-negates to the most-negative value and the remainder is 0.
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_den_s;
  logic [WIDTH-1:0] w_qm;
  logic [WIDTH-1:0] w_rm;
  logic [WIDTH-1:0] w_q_s;
  logic [WIDTH-1:0] w_r_s;
  logic [WIDTH-1:0] w_den_u;
  logic [WIDTH-1:0] w_q_u;
  logic [WIDTH-1:0] w_r_u;

  assign w_a_neg  = src_a[WIDTH-1];
  assign w_b_neg  = src_b[WIDTH-1];
  assign w_b_zero = (src_b == '0);
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  // A zero divisor is replaced by one so the divider never sees x/0; the
  // result is discarded anyway because the commit is suppressed.
  assign w_den_s  = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_qm     = w_a_mag / w_den_s;
  assign w_rm     = w_a_mag % w_den_s;
  assign w_q_s    = (w_a_neg ^ w_b_neg) ? -w_qm : w_qm;
  assign w_r_s    = w_a_neg ? -w_rm : w_rm;
  assign w_den_u  = w_b_zero ? WIDTH'(1) : src_b;
  assign w_q_u    = src_a / w_den_u;
  assign w_r_u    = src_a % w_den_u;
`endif

  // Control FSM, latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_wr    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            case (op)
              c_op_mult: begin
                r_p_hi  <= w_prod_s[2*WIDTH-1:WIDTH];
                r_p_lo  <= w_prod_s[WIDTH-1:0];
                r_wr    <= 1'b1;
                r_cnt   <= CW'(MULT_LAT);
                r_state <= c_run;
              end
              c_op_multu: begin
                r_p_hi  <= w_prod_u[2*WIDTH-1:WIDTH];
                r_p_lo  <= w_prod_u[WIDTH-1:0];
                r_wr    <= 1'b1;
                r_cnt   <= CW'(MULT_LAT);
                r_state <= c_run;
              end
`ifdef MD_UNIT_DIV_EN
              c_op_div: begin
                r_p_hi  <= w_r_s;
                r_p_lo  <= w_q_s;
                r_wr    <= !w_b_zero;
                r_cnt   <= CW'(DIV_LAT);
                r_state <= c_run;
              end
              c_op_divu: begin
                r_p_hi  <= w_r_u;
                r_p_lo  <= w_q_u;
                r_wr    <= !w_b_zero;
                r_cnt   <= CW'(DIV_LAT);
                r_state <= c_run;
              end
`endif
              c_op_mthi: r_hi <= src_a;
              c_op_mtlo: r_lo <= src_a;
              default: ;
            endcase
          end
        end
        c_run: begin
          // Requests arriving while running are dropped on purpose.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            if (r_wr) begin
              r_hi <= r_p_hi;
              r_lo <= r_p_lo;
            end
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy = (r_state == c_run);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed vector table,
//               multi-cycle corner sequences and randomized operations
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DLAT = DIV_EN ? DIV_LAT : 0;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  md_unit #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec  = 0;
  int nfail = 0;

  // Expected architectural HI/LO as seen before the operation in flight.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          elat;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: new HI/LO and busy length from plain arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ehi, output logic [31:0] elo, output int lat);
    longint      la, lb, q, r;
    logic [63:0] p;
    ehi = m_hi;
    elo = m_lo;
    lat = 0;
    case (o)
      3'd1: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        ehi = p[63:32]; elo = p[31:0]; lat = MULT_LAT;
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        ehi = p[63:32]; elo = p[31:0]; lat = MULT_LAT;
      end
      3'd3: if (DIV_EN) begin
        lat = DIV_LAT;
        if (b != 0) begin
          la = longint'($signed(a));
          lb = longint'($signed(b));
          q = la / lb;
          r = la % lb;
          elo = q[31:0]; ehi = r[31:0];
        end
      end
      3'd4: if (DIV_EN) begin
        lat = DIV_LAT;
        if (b != 0) begin
          elo = a / b; ehi = a % b;
        end
      end
      3'd5: ehi = a;
      3'd6: elo = a;
      default: ;
    endcase
  endtask

  // Issue one request and count busy cycles; HI/LO must hold while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cyc = 0;
    while (busy && cyc < 100) begin
      check("hold_hi", hi, m_hi);
      check("hold_lo", lo, m_lo);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          lat;
    logic [2:0]  ro;
    logic [31:0] ra, rb, ehi, elo;

    tbl[0]  = '{3'd1, 32'h3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MULT_LAT};
    tbl[1]  = '{3'd2, 32'h3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, MULT_LAT};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'h2,
                DIV_EN ? 32'hFFFFFFFF : 32'h2, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFFA, DLAT};
    tbl[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF,
                DIV_EN ? 32'h0 : 32'h2, DIV_EN ? 32'h80000000 : 32'hFFFFFFFA, DLAT};
    tbl[4]  = '{3'd5, 32'h11,       32'h0, 32'h11, DIV_EN ? 32'h80000000 : 32'hFFFFFFFA, 0};
    tbl[5]  = '{3'd6, 32'h22,       32'h0, 32'h11, 32'h22, 0};
    tbl[6]  = '{3'd4, 32'h7,        32'h0, 32'h11, 32'h22, DLAT};
    tbl[7]  = '{3'd0, 32'h5,        32'h6, 32'h11, 32'h22, 0};
    tbl[8]  = '{3'd7, 32'h5,        32'h6, 32'h11, 32'h22, 0};
    tbl[9]  = '{3'd3, 32'h64,       32'h7,
                DIV_EN ? 32'h2 : 32'h11, DIV_EN ? 32'hE : 32'h22, DLAT};
    tbl[10] = '{3'd4, 32'hFFFFFFFF, 32'h10,
                DIV_EN ? 32'hF : 32'h11, DIV_EN ? 32'h0FFFFFFF : 32'h22, DLAT};
    tbl[11] = '{3'd3, 32'h80000000, 32'h0,
                DIV_EN ? 32'hF : 32'h11, DIV_EN ? 32'h0FFFFFFF : 32'h22, DLAT};
    tbl[12] = '{3'd5, 32'hAAAA,     32'h0,
                32'hAAAA, DIV_EN ? 32'h0FFFFFFF : 32'h22, 0};

    reset = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      check($sformatf("tbl%0d_busy_cycles", i), 64'(cyc), 64'(tbl[i].elat));
      check($sformatf("tbl%0d_hi", i), hi, tbl[i].ehi);
      check($sformatf("tbl%0d_lo", i), lo, tbl[i].elo);
      m_hi = tbl[i].ehi;
      m_lo = tbl[i].elo;
    end

    // mtlo and a second mult during busy must both be dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd1; src_a = 32'h1234; src_b = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1'b1; op = 3'd6; src_a = 32'h5555;
      end else if (k == 3) begin
        start = 1'b1; op = 3'd1; src_a = 32'h7; src_b = 32'h7;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        check("ign_hold_hi", hi, m_hi);
        check("ign_hold_lo", lo, m_lo);
      end
      @(posedge clk); #1;
      cyc = k;
      if (!busy) break;
    end
    start = 1'b0; op = 3'd0;
    check("ign_busy_cycles", 64'(cyc), 64'(MULT_LAT));
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'h12340);
    repeat (3) @(posedge clk);
    #1;
    check("ign_lo_later", lo, 32'h12340);
    m_hi = 32'h0;
    m_lo = 32'h12340;

    // Reset in the middle of a long operation discards the pending result.
    run_op(3'd5, 32'h33, 32'h0, cyc);
    m_hi = 32'h33;
    check("pre_reset_hi", hi, 32'h33);
    @(negedge clk);
    start = 1'b1; op = DIV_EN ? 3'd3 : 3'd1; src_a = 32'h12345678; src_b = 32'h3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_hi", hi, 0);
    check("midrun_reset_lo", lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      check("post_reset_busy", busy, 0);
      check("post_reset_hi", hi, 0);
      check("post_reset_lo", lo, 0);
    end
    m_hi = '0;
    m_lo = '0;

    // Randomized operations against the reference model.
    for (int n = 0; n < 80; n++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model_op(ro, ra, rb, ehi, elo, lat);
      run_op(ro, ra, rb, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", n, ro), 64'(cyc), 64'(lat));
      check($sformatf("rnd%0d_op%0d_hi", n, ro), hi, ehi);
      check($sformatf("rnd%0d_op%0d_lo", n, ro), lo, elo);
      m_hi = ehi;
      m_lo = elo;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the pipelined core. It sits beside the ALU in the execute stage. The execute-stage control asserts `start` with an operation code and operands, and the unit computes for a configurable number of cycles while holding `busy`. The hazard unit stalls any mult/div/mfhi/mflo/mthi/mtlo while `start || busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_LAT`, 5: cycles of `busy` for mult/multu; must be ≥1.
- `DIV_LAT`, 10: cycles of `busy` for div/divu; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: operation request, sampled on the rising edge.
- `op` in 3: 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0 and 7 are no-op.
- `src_a` in WIDTH: rs operand (dividend/multiplicand/mthi-mtlo data).
- `src_b` in WIDTH: rt operand.
- `busy` out 1: long operation in progress.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE and RUN, plus a down-counter `cnt` of width clog2(max(MULT_LAT, DIV_LAT)) + 1.
- IDLE + `start` + mult/multu/div/divu:
  - Full result is computed from operands sampled this edge and captured into pending registers `p_hi`/`p_lo`.
  - `cnt` loads MULT_LAT or DIV_LAT; state goes to RUN.
- RUN: `cnt` decrements each edge. On the edge where `cnt==1`, `hi<=p_hi`, `lo<=p_lo`, and state goes to IDLE.
- `start` while RUN is ignored entirely. The hazard unit guarantees this does not occur; the unit tolerates it.
- mthi/mtlo in IDLE: `hi` or `lo` is written with `src_a` on the same edge, no `busy`. Ignored in RUN.
- mult: signed 2·WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits. multu: same, unsigned.
- div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Overflow (most-negative / −1): LO = most-negative, HI = 0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu): operation runs for the full DIV_LAT, `busy` as normal; HI and LO are left unchanged at completion.
- No-op codes with `start` are ignored.
- Reset assertion, including mid-RUN: state=IDLE, `cnt`=0, `busy`=0, `hi`=`lo`=`p_hi`=`p_lo`=0. The pending result is discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- `busy` is a registered output, equal to (state==RUN).
- Start sampled at edge E0: `busy` is high from after E0 through edge E_LAT. New `hi`/`lo` are visible after E_LAT, in the same cycle `busy` falls.
  - `busy` is high for exactly LAT cycles.
- mthi/mtlo: new value visible after the sampling edge; latency 1.
- Back-to-back: a `start` sampled in the cycle `busy` is low after completion is accepted. There is no dead cycle.
- `hi`/`lo` never change while `busy` is high. Only the completion edge, mthi/mtlo, or reset modifies them.

## Configuration
- `MD_UNIT_DIV_EN`:
  - Defined: div/divu are implemented as above.
  - Undefined: the divider logic is compiled out. op 3/4 are treated as no-op (no `busy`, HI/LO unchanged), `DIV_LAT` is unused, and the `cnt` width derives from MULT_LAT only.

## Test plan
- Reset low, then high; mult src_a=3, src_b=0xFFFFFFFE (MULT_LAT=5) -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div src_a=0xFFFFFFF9 (−7), src_b=2 -> `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge cases: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; divu 7/0 with prior hi=0x11, lo=0x22 -> `busy` 10 cycles, hi/lo remain 0x11/0x22.
- mthi 0xAAAA in IDLE -> hi=0xAAAA next cycle. Start mult, then mtlo 0x5555 and a second mult during `busy` -> both ignored; lo equals only the first product.
- Start div, assert reset at cycle 4 -> `busy`, hi and lo are 0 immediately, and no completion write occurs after reset release.
- Compile without `MD_UNIT_DIV_EN`: div start -> `busy` stays 0, hi/lo unchanged.
